bin2bcd8: RTL and testbench

Sequential binary-to-packed-BCD converter using shift-and-add-3 (double dabble), one input bit per clock. It sits directly upstream of the 8-digit seven-segment scanner. Its 32-bit packed BCD output (8 digits, most significant digit in [31:28]) drives the scanner's 32-bit display-data input, so the scanner shows decimal values instead of hex. It uses a start/busy/done handshake so producers (counters, ADC readers) can request a conversion at any time.

---
 rtl/bin2bcd8.sv | 160 ++++++++++++++++
 tb/tb_bin2bcd8.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd8.sv
// -----------------------------------------------------------------------------
// bin2bcd8 -- sequential binary to packed-BCD converter (shift-and-add-3).
//
// Converts an unsigned BIN_W-bit value into 8 packed BCD digits, consuming one
// input bit per clock.
//
// Latency: Start is accepted on edge 0, shifts happen on edges 1..BIN_W, and
// the result is published on edge BIN_W+1 together with a one-cycle Done.
// Back-to-back conversions therefore repeat every BIN_W+2 cycles.
//
// Bcd_data and Ovf only change on the Done edge, so the downstream display
// never sees a partially converted value.
//
// Ports:
//   Clk       in   system clock
//   Reset_n   in   asynchronous, active-low reset
//   Start     in   conversion request, only looked at while idle
//   Bin       in   BIN_W-bit unsigned value, captured when Start is accepted
//   Busy      out  high while a conversion is running
//   Done      out  one-cycle pulse; Bcd_data/Ovf valid from this cycle
//   Bcd_data  out  8 packed BCD digits, digit 7 in [31:28], digit 0 in [3:0]
//   Ovf       out  last result exceeded 99,999,999
//
// Parameter:
//   BIN_W     input width, 1..32 (default 27)
//
// Optional feature macro: BIN2BCD8_SAT_EN
//   defined   -> an overflowing result is shown as 9999_9999
//   undefined -> the low 8 digits are shown (modulo 10^8 wrap)
// -----------------------------------------------------------------------------
module bin2bcd8 #(
   parameter int BIN_W = 27
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic [BIN_W-1:0] Bin,
   output logic             Busy,
   output logic             Done,
   output logic [31:0]      Bcd_data,
   output logic             Ovf
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
   localparam logic [1:0] ST_FINISH = 2'd2;

   localparam logic [5:0] LAST_ITER = 6'(BIN_W - 1);

   logic [1:0]       state_q,   state_d;
   logic [BIN_W-1:0] bin_sr_q,  bin_sr_d;
   logic [39:0]      scratch_q, scratch_d;
   logic [5:0]       cnt_q,     cnt_d;
   logic             busy_q,    busy_d;
   logic             done_q,    done_d;
   logic [31:0]      bcd_q,     bcd_d;
   logic             ovf_q,     ovf_d;

   logic [39:0]       scratch_adj;
   logic [39+BIN_W:0] shifted;
   logic              ovf_now;

   // Add-3 correction: every digit >= 5 is bumped by 3 before the shift,
   // so that it carries correctly into the next decimal digit once doubled.
   always_comb begin
      scratch_adj = scratch_q;
      for (int i = 0; i < 10; i++) begin
         if (scratch_q[i*4 +: 4] >= 4'd5) begin
            scratch_adj[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
         end
      end
   end

   // The scratch and binary registers shift as a single chain, so the
   // binary MSB enters scratch bit 0.
   assign shifted = {scratch_adj, bin_sr_q} << 1;

   // The two digits above the displayed eight are non-zero only when
   // the value exceeds 99,999,999.
   assign ovf_now = (scratch_q[39:32] != 8'h00);

   // Next-state logic for the converter FSM and its datapath.
   always_comb begin
      state_d   = state_q;
      bin_sr_d  = bin_sr_q;
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      bcd_d     = bcd_q;
      ovf_d     = ovf_q;

      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               bin_sr_d  = Bin;
               scratch_d = 40'h0;
               cnt_d     = 6'd0;
               busy_d    = 1'b1;
               state_d   = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            scratch_d = shifted[39+BIN_W:BIN_W];
            bin_sr_d  = shifted[BIN_W-1:0];
            cnt_d     = cnt_q + 6'd1;
            if (cnt_q == LAST_ITER) begin
               state_d = ST_FINISH;
            end
         end

         ST_FINISH: begin
            ovf_d = ovf_now;
`ifdef BIN2BCD8_SAT_EN
            bcd_d = ovf_now ? 32'h9999_9999 : scratch_q[31:0];
`else
            bcd_d = scratch_q[31:0];
`endif
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any running conversion.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= ST_IDLE;
         bin_sr_q  <= '0;
         scratch_q <= 40'h0;
         cnt_q     <= 6'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         bcd_q     <= 32'h0000_0000;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bin_sr_q  <= bin_sr_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         bcd_q     <= bcd_d;
         ovf_q     <= ovf_d;
      end
   end

   assign Busy     = busy_q;
   assign Done     = done_q;
   assign Bcd_data = bcd_q;
   assign Ovf      = ovf_q;

endmodule

// File: tb/tb_bin2bcd8.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd8 -- self-checking bench for bin2bcd8 (default BIN_W = 27).
// The expected BCD is derived from decimal arithmetic on the input value.
// -----------------------------------------------------------------------------
module tb_bin2bcd8;

   localparam int BIN_W = 27;
   localparam int MAX_WAIT = 100;

   logic             Clk;
   logic             Reset_n;
   logic             Start;
   logic [BIN_W-1:0] Bin;
   logic             Busy;
   logic             Done;
   logic [31:0]      Bcd_data;
   logic             Ovf;

   int compared;
   int mismatched;

   bin2bcd8 #(.BIN_W(BIN_W)) dut (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .Start    (Start),
      .Bin      (Bin),
      .Busy     (Busy),
      .Done     (Done),
      .Bcd_data (Bcd_data),
      .Ovf      (Ovf)
   );

   // 100 MHz free-running clock.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Reference: decimal digits by repeated division, with optional saturation.
   function automatic logic [31:0] refBcd(input longint unsigned v);
      logic [31:0] r;
      longint unsigned t;
      r = 32'h0;
      t = v % 64'd100000000;
      for (int i = 0; i < 8; i++) begin
         r[i*4 +: 4] = 4'(t % 10);
         t = t / 10;
      end
`ifdef BIN2BCD8_SAT_EN
      if (v > 64'd99999999) r = 32'h9999_9999;
`endif
      return r;
   endfunction

   function automatic logic refOvf(input longint unsigned v);
      return (v > 64'd99999999);
   endfunction

   // One comparison: count it, and on a miss count and report it.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic start, input logic [BIN_W-1:0] bin);
      Start = start;
      Bin   = bin;
   endtask

   // Advance one clock edge and settle just after it.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Full single conversion with a one-cycle Start; checks latency and result.
   task automatic runConversion(input string tag, input longint unsigned v);
      int n;
      int busyCycles;
      bit seen;
      applyStimulus(1'b1, BIN_W'(v));
      tick();
      applyStimulus(1'b0, BIN_W'($urandom));
      busyCycles = Busy ? 1 : 0;
      n = 0;
      seen = 0;
      while (!seen && n < MAX_WAIT) begin
         tick();
         n++;
         if (Busy) busyCycles++;
         if (Done) seen = 1;
      end
      checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
      checkOutput({tag, "_latency"}, 32'(n), 32'(BIN_W + 1));
      checkOutput({tag, "_busy_cycles"}, 32'(busyCycles), 32'(BIN_W + 1));
      checkOutput({tag, "_bcd"}, Bcd_data, refBcd(v));
      checkOutput({tag, "_ovf"}, {31'b0, Ovf}, {31'b0, refOvf(v)});
      tick();
      checkOutput({tag, "_done_drop"}, {31'b0, Done}, 32'd0);
   endtask

   initial begin
      int doneCount;
      int doneEdge;
      int firstEdge;
      logic [31:0] cap;
      logic [31:0] cap2;
      longint unsigned rv;
      longint unsigned a;

      compared   = 0;
      mismatched = 0;
      Reset_n    = 1'b0;
      applyStimulus(1'b0, '0);
      repeat (3) tick();

      // Reset state.
      checkOutput("rst_busy", {31'b0, Busy}, 32'd0);
      checkOutput("rst_done", {31'b0, Done}, 32'd0);
      checkOutput("rst_bcd", Bcd_data, 32'h0);
      checkOutput("rst_ovf", {31'b0, Ovf}, 32'd0);
      Reset_n = 1'b1;
      tick();

      // Directed values, including the overflow boundaries.
      runConversion("zero", 64'd0);
      runConversion("v12345678", 64'd12345678);
      checkOutput("v12345678_const", Bcd_data, 32'h1234_5678);
      runConversion("v99999999", 64'd99999999);
      checkOutput("v99999999_const", Bcd_data, 32'h9999_9999);
      runConversion("v100000000", 64'd100000000);
      runConversion("vmax", 64'd134217727);

      // Outputs hold between conversions.
      repeat (5) tick();
      checkOutput("hold_bcd", Bcd_data, refBcd(64'd134217727));
      checkOutput("hold_ovf", {31'b0, Ovf}, 32'd1);

      // Random values across the full input range.
      for (int r = 0; r < 12; r++) begin
         rv = longint'($urandom_range(0, (1 << BIN_W) - 1));
         runConversion("rand", rv);
      end

      // Start re-pulsed mid-conversion is ignored.
      a = 64'd4321;
      applyStimulus(1'b1, BIN_W'(a));
      tick();
      doneCount = 0;
      doneEdge  = 0;
      cap       = 32'h0;
      for (int k = 1; k <= 60; k++) begin
         if (k == 10) applyStimulus(1'b1, BIN_W'(64'd8765));
         else         applyStimulus(1'b0, BIN_W'(64'd8765));
         tick();
         if (Done) begin
            doneCount++;
            doneEdge = k;
            cap = Bcd_data;
         end
      end
      checkOutput("repulse_count", 32'(doneCount), 32'd1);
      checkOutput("repulse_edge", 32'(doneEdge), 32'(BIN_W + 1));
      checkOutput("repulse_bcd", cap, refBcd(a));

      // Start held high: back-to-back conversions, Bin switched at first Done.
      applyStimulus(1'b1, BIN_W'(64'd5));
      tick();
      doneCount = 0;
      firstEdge = 0;
      doneEdge  = 0;
      cap       = 32'h0;
      cap2      = 32'h0;
      for (int k = 1; k <= 80 && doneCount < 2; k++) begin
         tick();
         if (Done) begin
            doneCount++;
            if (doneCount == 1) begin
               firstEdge = k;
               cap = Bcd_data;
               Bin = BIN_W'(64'd42);
            end else begin
               doneEdge = k;
               cap2 = Bcd_data;
               Start = 1'b0;
            end
         end
      end
      Start = 1'b0;
      checkOutput("held_count", 32'(doneCount), 32'd2);
      checkOutput("held_first", cap, 32'h0000_0005);
      checkOutput("held_second", cap2, 32'h0000_0042);
      checkOutput("held_spacing", 32'(doneEdge - firstEdge), 32'(BIN_W + 2));
      repeat (3) tick();

      // Reset mid-conversion after an overflowing result.
      runConversion("pre_reset", 64'd134217727);
      applyStimulus(1'b1, BIN_W'(64'd123));
      tick();
      applyStimulus(1'b0, BIN_W'(64'd123));
      repeat (14) tick();
      Reset_n = 1'b0;
      #1;
      checkOutput("midrst_busy", {31'b0, Busy}, 32'd0);
      checkOutput("midrst_done", {31'b0, Done}, 32'd0);
      checkOutput("midrst_bcd", Bcd_data, 32'h0);
      checkOutput("midrst_ovf", {31'b0, Ovf}, 32'd0);
      tick();
      Reset_n = 1'b1;
      tick();
      runConversion("after_reset", 64'd7);
      checkOutput("after_reset_const", Bcd_data, 32'h0000_0007);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
